// File: rtl/key_pkg.sv
// Shared constants and arbiter state encoding for the key conditioning block.
package key_pkg;

  localparam int unsigned DEB_CYC_DEF = 500000;
  localparam int unsigned CNT_W_DEF   = 20;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    HOLD_A = 2'b01,
    HOLD_B = 2'b10
  } arb_state_e;

endpackage

// File: rtl/key_debounce.sv
// One key channel: 2-flop synchronizer, stability counter and accepted level.
// level_c is the level the channel will hold after the coming edge.
module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned DEB_CYC = DEB_CYC_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic clk,
  input  logic clr,
  input  logic key_raw,
  output logic level_c
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYC - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Accept a new level only after DEB_CYC consecutive disagreeing samples.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= key_raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign level_c = stable_d;

endmodule

// File: rtl/key_conditioner.sv
// Debounces the two hold keys and the pause button, arbitrates the holds
// (A wins ties), toggles pause and pulses mode_chg on any output change.
module key_conditioner
  import key_pkg::*;
#(
  parameter int unsigned DEB_CYC = DEB_CYC_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic clk,
  input  logic clr,
  input  logic key_stopa,
  input  logic key_stopb,
  input  logic key_pause,
  output logic stopa,
  output logic stopb,
  output logic pause,
  output logic mode_chg
);

  logic       lvl_a_c, lvl_b_c, lvl_p_c;
  logic       lvl_p_q;
  arb_state_e state_q, state_d;
  logic       stopa_q, stopa_d;
  logic       stopb_q, stopb_d;
  logic       pause_q, pause_d;
  logic       mode_chg_q, mode_chg_d;

  key_debounce #(.DEB_CYC(DEB_CYC), .CNT_W(CNT_W)) u_deb_a (
    .clk(clk), .clr(clr), .key_raw(key_stopa), .level_c(lvl_a_c)
  );
  key_debounce #(.DEB_CYC(DEB_CYC), .CNT_W(CNT_W)) u_deb_b (
    .clk(clk), .clr(clr), .key_raw(key_stopb), .level_c(lvl_b_c)
  );
  key_debounce #(.DEB_CYC(DEB_CYC), .CNT_W(CNT_W)) u_deb_p (
    .clk(clk), .clr(clr), .key_raw(key_pause), .level_c(lvl_p_c)
  );

  // Arbiter reacts on the same edge the debounced level is accepted.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (lvl_a_c)      state_d = HOLD_A;
        else if (lvl_b_c) state_d = HOLD_B;
      end
      HOLD_A:  if (!lvl_a_c) state_d = IDLE;
      HOLD_B:  if (!lvl_b_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    stopa_d = (state_d == HOLD_A);
    stopb_d = (state_d == HOLD_B);

    // Entering a hold clears pause; presses only count while idle.
    pause_d = pause_q;
    if (state_d != IDLE) begin
      pause_d = 1'b0;
    end else if ((state_q == IDLE) && lvl_p_c && !lvl_p_q) begin
      pause_d = !pause_q;
    end

    mode_chg_d = (stopa_d ^ stopa_q) | (stopb_d ^ stopb_q) | (pause_d ^ pause_q);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= IDLE;
      lvl_p_q    <= 1'b0;
      stopa_q    <= 1'b0;
      stopb_q    <= 1'b0;
      pause_q    <= 1'b0;
      mode_chg_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lvl_p_q    <= lvl_p_c;
      stopa_q    <= stopa_d;
      stopb_q    <= stopb_d;
      pause_q    <= pause_d;
      mode_chg_q <= mode_chg_d;
    end
  end

  assign stopa    = stopa_q;
  assign stopb    = stopb_q;
  assign pause    = pause_q;
  assign mode_chg = mode_chg_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner at DEB_CYC=4: directed scenarios plus random key
// activity, every cycle compared against a behavioural reference model.
module tb_key_conditioner;

  localparam int unsigned DEB = 4;
  localparam int unsigned CW  = 3;

  logic clk, clr;
  logic key_stopa, key_stopb, key_pause;
  logic stopa, stopb, pause, mode_chg;

  key_conditioner #(.DEB_CYC(DEB), .CNT_W(CW)) dut (
    .clk(clk), .clr(clr),
    .key_stopa(key_stopa), .key_stopb(key_stopb), .key_pause(key_pause),
    .stopa(stopa), .stopb(stopb), .pause(pause), .mode_chg(mode_chg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic mc_seen;

  // Reference model: raw-sample history, run length of disagreeing samples,
  // accepted levels, hold owner (0 none, 1 A, 2 B), pause, outputs.
  bit m_s1[3], m_s2[3], m_lvl[3];
  int m_run[3];
  int m_owner;
  bit m_stopa, m_stopb, m_pause, m_mc;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_run[i] = 0;
    end
    m_owner = 0; m_stopa = 0; m_stopb = 0; m_pause = 0; m_mc = 0;
  endtask

  task automatic model_edge();
    bit raw[3];
    bit old_p, ns_a, ns_b, np;
    int old_owner;
    raw[0] = key_stopa; raw[1] = key_stopb; raw[2] = key_pause;
    old_p = m_lvl[2];
    for (int i = 0; i < 3; i++) begin
      m_run[i] = (m_s2[i] != m_lvl[i]) ? m_run[i] + 1 : 0;
      if (m_run[i] >= int'(DEB)) begin
        m_lvl[i] = m_s2[i];
        m_run[i] = 0;
      end
      m_s2[i] = m_s1[i];
      m_s1[i] = raw[i];
    end
    old_owner = m_owner;
    if (m_owner == 0)                   m_owner = m_lvl[0] ? 1 : (m_lvl[1] ? 2 : 0);
    else if (m_owner == 1 && !m_lvl[0]) m_owner = 0;
    else if (m_owner == 2 && !m_lvl[1]) m_owner = 0;
    np = m_pause;
    if (m_owner != 0)                             np = 0;
    else if (old_owner == 0 && m_lvl[2] && !old_p) np = !m_pause;
    ns_a = (m_owner == 1);
    ns_b = (m_owner == 2);
    m_mc = (ns_a != m_stopa) || (ns_b != m_stopb) || (np != m_pause);
    m_stopa = ns_a; m_stopb = ns_b; m_pause = np;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    if (mode_chg === 1'b1) mc_seen = 1'b1;
    check_eq("m_stopa", stopa, m_stopa);
    check_eq("m_stopb", stopb, m_stopb);
    check_eq("m_pause", pause, m_pause);
    check_eq("m_mode_chg", mode_chg, m_mc);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_clr(input string tag);
    clr = 1'b1;
    model_reset();
    #1;
    check_eq({tag, "_stopa"}, stopa, 0);
    check_eq({tag, "_stopb"}, stopb, 0);
    check_eq({tag, "_pause"}, pause, 0);
    check_eq({tag, "_mc"}, mode_chg, 0);
    #1 clr = 1'b0;
  endtask

  initial begin
    key_stopa = 0; key_stopb = 0; key_pause = 0; mc_seen = 0;
    pulse_clr("rst");
    steps(3);

    // Short bounce on A never accepted
    mc_seen = 0;
    key_stopa = 1; step();
    key_stopa = 0; step();
    key_stopa = 1; step();
    key_stopa = 0; steps(10);
    check_eq("bounce_stopa", stopa, 0);
    check_eq("bounce_mc_seen", mc_seen, 0);

    // A press latency: first sampled edge k, stopa set on edge k+DEB+1
    key_stopa = 1;
    for (int i = 0; i < int'(DEB) + 1; i++) begin
      step();
      check_eq("a_early", stopa, 0);
    end
    step();
    check_eq("a_rise", stopa, 1);
    check_eq("a_rise_mc", mode_chg, 1);
    step();
    check_eq("a_mc_once", mode_chg, 0);
    key_stopa = 0;
    steps(DEB + 1);
    check_eq("a_rel_early", stopa, 1);
    step();
    check_eq("a_rel", stopa, 0);
    check_eq("a_rel_mc", mode_chg, 1);
    steps(3);

    // Simultaneous A and B: A wins, B follows one edge after A drops
    key_stopa = 1; key_stopb = 1;
    steps(DEB + 2);
    check_eq("both_a", stopa, 1);
    check_eq("both_b", stopb, 0);
    key_stopa = 0;
    steps(DEB + 2);
    check_eq("hand_a", stopa, 0);
    check_eq("hand_b_wait", stopb, 0);
    step();
    check_eq("hand_b", stopb, 1);
    check_eq("hand_mc", mode_chg, 1);
    key_stopb = 0;
    steps(DEB + 3);
    check_eq("b_rel", stopb, 0);

    // Two clean pause presses toggle 0->1->0
    key_pause = 1; steps(DEB + 2);
    check_eq("p_on", pause, 1);
    key_pause = 0; steps(DEB + 2);
    check_eq("p_release", pause, 1);
    key_pause = 1; steps(DEB + 2);
    check_eq("p_off", pause, 0);
    key_pause = 0; steps(DEB + 2);

    // Press during HOLD_B ignored
    key_stopb = 1; steps(DEB + 2);
    check_eq("hb_stopb", stopb, 1);
    key_pause = 1; steps(DEB + 2);
    check_eq("hb_pause", pause, 0);
    key_pause = 0; steps(DEB + 2);
    key_stopb = 0; steps(DEB + 3);
    check_eq("hb_after", pause, 0);

    // Pause set, then A press clears pause on the same edge with one pulse
    key_pause = 1; steps(DEB + 2);
    key_pause = 0; steps(DEB + 2);
    check_eq("pa_pause_set", pause, 1);
    key_stopa = 1;
    steps(DEB + 1);
    check_eq("pa_before", pause, 1);
    step();
    check_eq("pa_stopa", stopa, 1);
    check_eq("pa_pause", pause, 0);
    check_eq("pa_mc", mode_chg, 1);
    step();
    check_eq("pa_mc_once", mode_chg, 0);

    // Reset mid-hold with A still held: full debounce again
    pulse_clr("clr_hold");
    steps(DEB + 1);
    check_eq("clr_early", stopa, 0);
    step();
    check_eq("clr_restart", stopa, 1);
    key_stopa = 0;
    steps(DEB + 3);

    // Random key activity with occasional resets
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) key_stopa = ~key_stopa;
      if ($urandom_range(0, 5) == 0) key_stopb = ~key_stopb;
      if ($urandom_range(0, 3) == 0) key_pause = ~key_pause;
      if ($urandom_range(0, 499) == 0) pulse_clr("rnd_clr");
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
